// File: rtl/nbit_alu_pkg.sv
// Shared opcode constants, FSM state encoding and flag bit positions for the sequential ALU.
package nbit_alu_pkg;

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_NOT = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // flags bus is {negative, zero, carry, overflow}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] mk_flags(input logic neg, input logic zero,
                                            input logic carry, input logic ovf);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = neg;
        f[FLAG_Z] = zero;
        f[FLAG_C] = carry;
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/nbit_alu_seq_if.sv
// Request/result handshake bundle of the sequential ALU; master issues ops and consumes results.
interface nbit_alu_seq_if #(parameter int N = 32) ();

    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUop;
    logic [N-1:0] r2;
    logic [N-1:0] r3;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] r0;
    logic [3:0]   flags;

    modport master (
        output in_valid, ALUop, r2, r3, out_ready,
        input  in_ready, out_valid, r0, flags
    );

    modport slave (
        input  in_valid, ALUop, r2, r3, out_ready,
        output in_ready, out_valid, r0, flags
    );

endinterface

// File: rtl/nbit_alu_comb.sv
// Combinational datapath for the single-cycle ops (everything except MUL).
// Pure logic, no latency or flow control of its own; MUL opcode yields zero.
module nbit_alu_comb
    import nbit_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    logic [N:0] sum;
    logic [N:0] diff;
    logic       carry;
    logic       ovf;

    // The extra top bit of diff is the unsigned borrow (set exactly when a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_MOV: result = a;
            OP_NOT: result = ~a;
            OP_ADD: begin
                result = sum[N-1:0];
                carry  = sum[N];
                ovf    = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                result = diff[N-1:0];
                carry  = diff[N];
                ovf    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_OR:  result = a | b;
            OP_AND: result = a & b;
            OP_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
        flags = mk_flags(result[N-1], (result == '0), carry, ovf);
    end

endmodule

// File: rtl/nbit_alu_seq.sv
// Sequential N-bit ALU: ops 0-6 complete at the accepting edge, MUL takes N shift-add cycles.
// One result slot; in_ready drops while MUL iterates or while a held result is not taken.
module nbit_alu_seq
    import nbit_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    nbit_alu_seq_if.slave bus
);

    localparam int CW = $clog2(N) + 1;

    state_t        state;
    logic [N-1:0]  r0_q;
    logic [3:0]    flags_q;
    logic [N-1:0]  mcand;
    logic [N-1:0]  prod_hi;
    logic [N-1:0]  prod_lo;
    logic [CW-1:0] cnt;

    logic          in_rdy;
    logic          accept;
    logic [N-1:0]  comb_res;
    logic [3:0]    comb_flags;
    logic [N:0]    addend;
    logic [N:0]    step_sum;
    logic [N-1:0]  next_hi;
    logic [N-1:0]  next_lo;

    assign in_rdy        = (state == ST_IDLE) || ((state == ST_FULL) && bus.out_ready);
    assign accept        = bus.in_valid && in_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == ST_FULL);
    assign bus.r0        = r0_q;
    assign bus.flags     = flags_q;

    nbit_alu_comb #(.N(N)) u_comb (
        .op     (bus.ALUop),
        .a      (bus.r2),
        .b      (bus.r3),
        .result (comb_res),
        .flags  (comb_flags)
    );

    // One shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, hi, lo} product right by one.
    assign addend   = prod_lo[0] ? {1'b0, mcand} : '0;
    assign step_sum = {1'b0, prod_hi} + addend;
    assign next_hi  = step_sum[N:1];
    assign next_lo  = {step_sum[0], prod_lo[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            r0_q    <= '0;
            flags_q <= '0;
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (bus.ALUop == OP_MUL) begin
                mcand   <= bus.r2;
                prod_lo <= bus.r3;
                prod_hi <= '0;
                cnt     <= CW'(N);
                state   <= ST_BUSY;
            end else begin
                r0_q    <= comb_res;
                flags_q <= comb_flags;
                state   <= ST_FULL;
            end
        end else begin
            case (state)
                ST_BUSY: begin
                    prod_hi <= next_hi;
                    prod_lo <= next_lo;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        r0_q    <= next_lo;
                        flags_q <= mk_flags(next_lo[N-1], (next_lo == '0),
                                            |next_hi, |next_hi);
                        state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nbit_alu_seq.sv
// Bench for nbit_alu_seq: directed corner cases, then random traffic against a transaction-level model.
module tb_nbit_alu_seq;
    import nbit_alu_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nbit_alu_seq_if #(.N(N)) bus ();

    nbit_alu_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, returns {r0, negative, zero, carry, overflow}.
    function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint             sa, sb, ws;
        logic        [63:0] p;
        logic        [31:0] r;
        logic signed [31:0] rs;
        logic               c, v;
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: r = a;
            3'd1: r = ~a;
            3'd2: begin
                r  = a + b;
                p  = {32'b0, a} + {32'b0, b};
                c  = (p > 64'hffff_ffff);
                ws = sa + sb;
                rs = r;
                v  = (ws != rs);
            end
            3'd3: begin
                r  = a - b;
                c  = (a < b);
                ws = sa - sb;
                rs = r;
                v  = (ws != rs);
            end
            3'd4: r = a | b;
            3'd5: r = a & b;
            3'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0];
                c = (p[63:32] != 0);
                v = c;
            end
        endcase
        return {r, r[31], (r == 0), c, v};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with the consumer stalled, wait for the result, compare, then drain it.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                         input int lat);
        int waited;
        int busy;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ALUop     = op;
        bus.r2        = a;
        bus.r3        = b;
        #1 check({tag, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ALUop    = 3'($urandom);
        bus.r2       = $urandom;
        bus.r3       = $urandom;
        waited = 0;
        busy   = 0;
        while (!bus.out_valid && waited < 100) begin
            if (!bus.in_ready) busy++;
            @(negedge clk);
            waited++;
        end
        check({tag, "_latency"}, waited, lat);
        check({tag, "_busy_cycles"}, busy, lat);
        check({tag, "_r0"}, bus.r0, er);
        check({tag, "_flags"}, bus.flags, ef);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drained"}, bus.out_valid, 0);
    endtask

    logic        pend;
    int          wait_c;
    logic [35:0] exp_v;
    logic        e_ov, e_ir, fire_in, fire_out, stale;

    initial begin
        bus.in_valid  = 1'b0;
        bus.ALUop     = 3'd0;
        bus.r2        = '0;
        bus.r3        = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_r0", bus.r0, 0);
        check("rst_flags", bus.flags, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", bus.in_ready, 1);

        do_op("add_ovf", OP_ADD, 32'h7fff_ffff, 32'h7fff_ffff, 32'hffff_fffe, 4'b1001, 0);
        do_op("sub_borrow", OP_SUB, 32'd2, 32'd3, 32'hffff_ffff, 4'b1010, 0);
        do_op("slt_neg", OP_SLT, 32'hffff_fffe, 32'd3, 32'd1, 4'b0000, 0);
        do_op("mul_hi", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0111, N);
        do_op("mul_small", OP_MUL, 32'd3, 32'd5, 32'hf, 4'b0000, N);
        do_op("not_zero", OP_NOT, 32'h0, 32'h1234_5678, 32'hffff_ffff, 4'b1000, 0);
        do_op("and_zero", OP_AND, 32'h0000_f0f0, 32'h0000_0f0f, 32'h0, 4'b0100, 0);

        // Reset wins over an acceptance in the same cycle.
        bus.in_valid = 1'b1;
        bus.ALUop    = OP_ADD;
        bus.r2       = 32'd1;
        bus.r3       = 32'd1;
        rst          = 1'b1;
        @(negedge clk);
        check("rst_prio_valid", bus.out_valid, 0);
        check("rst_prio_r0", bus.r0, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: held ADD blocks OR until the consumer is ready.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ALUop     = OP_ADD;
        bus.r2        = 32'd5;
        bus.r3        = 32'd6;
        @(negedge clk);
        check("bp_add_valid", bus.out_valid, 1);
        check("bp_add_r0", bus.r0, 32'd11);
        bus.ALUop = OP_OR;
        bus.r2    = 32'h0000_00f0;
        bus.r3    = 32'h0000_000f;
        #1 check("bp_blocked_rdy", bus.in_ready, 0);
        @(negedge clk);
        check("bp_hold_r0", bus.r0, 32'd11);
        check("bp_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        #1 check("bp_release_rdy", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_or_valid", bus.out_valid, 1);
        check("bp_or_r0", bus.r0, 32'h0000_00ff);
        @(negedge clk);
        check("bp_or_consumed", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Reset ten cycles into a MUL; the aborted product must never surface.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ALUop     = OP_MUL;
        bus.r2        = 32'hffff_ffff;
        bus.r3        = 32'hffff_ffff;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", bus.out_valid, 0);
        check("abort_r0", bus.r0, 0);
        check("abort_flags", bus.flags, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rdy", bus.in_ready, 1);
        stale = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("abort_no_stale", stale, 0);
        do_op("mov_after_abort", OP_MOV, 32'hb1ee_c082, 32'h0, 32'hb1ee_c082, 4'b1000, 0);

        // Random traffic against a slot/latency model.
        pend   = 1'b0;
        wait_c = 0;
        exp_v  = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            e_ov = pend && (wait_c == 0);
            check("rnd_out_valid", bus.out_valid, e_ov);
            if (e_ov && bus.out_valid) begin
                check("rnd_r0", bus.r0, exp_v[35:4]);
                check("rnd_flags", bus.flags, exp_v[3:0]);
            end
            bus.in_valid = ($urandom_range(0, 9) < 6);
            bus.ALUop    = 3'($urandom_range(0, 7));
            if (bus.ALUop == OP_MUL && $urandom_range(0, 2) != 0)
                bus.ALUop = 3'($urandom_range(0, 6));
            bus.r2        = pick_operand();
            bus.r3        = pick_operand();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            e_ir = !pend || ((wait_c == 0) && bus.out_ready);
            check("rnd_in_ready", bus.in_ready, e_ir);
            fire_out = e_ov && bus.out_ready;
            fire_in  = bus.in_valid && e_ir;
            if (fire_out) pend = 1'b0;
            if (wait_c > 0) wait_c--;
            if (fire_in) begin
                pend   = 1'b1;
                exp_v  = ref_alu(bus.ALUop, bus.r2, bus.r3);
                wait_c = (bus.ALUop == OP_MUL) ? N : 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nbit_alu_seq.md
NBIT_ALU_SEQ -- requirements
Module: nbit_alu_seq

Interface
REQ-001 Parameter N, default 32, SHALL set the operand and result width (legal N >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL flag that an operation request is present.
REQ-005 in_ready  output  1  SHALL flag that the block accepts a request this cycle.
REQ-006 ALUop  input  3  SHALL select the operation: 0 MOV, 1 NOT, 2 ADD, 3 SUB, 4 OR, 5 AND, 6 SLT, 7 MUL.
REQ-007 r2  input  N  SHALL be operand A.
REQ-008 r3  input  N  SHALL be operand B (ignored for MOV and NOT).
REQ-009 out_valid  output  1  SHALL flag that r0 and the flags hold a valid result.
REQ-010 out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-011 r0  output  N  SHALL be the registered result.
REQ-012 flags  output  4  SHALL be {negative, zero, carry, overflow}, registered with r0.

Function
REQ-013 Acceptance SHALL occur on a rising edge where in_valid && in_ready; ALUop, r2 and r3 are captured then, and later input changes have no effect on that operation.
REQ-014 The FSM SHALL have states IDLE (no result), BUSY (MUL iterating) and FULL (result held).
REQ-015 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in FULL.
REQ-016 Ops 0-6 SHALL have latency 1: the result is registered at the accepting edge, and the state goes to FULL.
REQ-017 MUL SHALL be an unsigned shift-add over N BUSY cycles; out_valid rises N cycles after the accepting edge, and the state goes BUSY->FULL.
REQ-018 In FULL with out_ready=1 and no new acceptance, the state SHALL return to IDLE and out_valid SHALL fall.
REQ-019 In FULL with out_ready=1 and a simultaneous acceptance, the old result SHALL be consumed and the new op SHALL proceed with no bubble: FULL for ops 0-6, BUSY for MUL.
REQ-020 While out_valid && !out_ready, r0 and flags SHALL stay stable.
REQ-021 out_valid SHALL be 1 only in FULL.
REQ-022 MOV: r0=r2; NOT: r0=~r2; OR: r0=r2|r3; AND: r0=r2&r3; for all four, carry=0 and overflow=0.
REQ-023 ADD: r0=(r2+r3) mod 2^N; carry=unsigned carry-out; overflow=signed overflow.
REQ-024 SUB: r0=(r2-r3) mod 2^N; carry=borrow (r2<r3 unsigned); overflow=signed overflow.
REQ-025 SLT: r0=1 if $signed(r2)<$signed(r3), else 0; carry=0 and overflow=0.
REQ-026 MUL: r0=low N bits of r2*r3; carry=overflow=1 if any of the high N product bits is nonzero.
REQ-027 For every op, negative=r0[N-1] and zero=(r0==0).
REQ-028 The MUL iteration counter SHALL be $clog2(N)+1 bits wide and SHALL reload on every MUL acceptance.

Reset
REQ-029 While rst=1, the state SHALL be IDLE, r0=0, flags=0, out_valid=0 and the counter=0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 rst asserted during BUSY or FULL SHALL abort the operation without emitting a result.
REQ-031 rst SHALL take priority over a simultaneous acceptance.

Structure
REQ-032 A shared package nbit_alu_pkg SHALL hold the opcode constants (OP_MOV..OP_MUL), the FSM state encoding and the flag bit indices.
REQ-033 Single-cycle ops SHALL be implemented in the sub-module nbit_alu_comb (combinational, parameter N, outputs result and flags).
REQ-034 The MUL datapath and FSM SHALL reside in nbit_alu_seq.

Verification (N=32)
REQ-035 ADD r2=7fff_ffff, r3=7fff_ffff -> one cycle later out_valid=1, r0=ffff_fffe, flags={1,0,0,1}.
REQ-036 SUB r2=2, r3=3 -> r0=ffff_ffff, flags={1,0,1,0}; SLT r2=ffff_fffe, r3=3 -> r0=1, flags={0,0,0,0}.
REQ-037 MUL r2=0001_0000, r3=0001_0000 -> in_ready=0 for 32 cycles, then out_valid=1, r0=0, flags={0,1,1,1}; MUL r2=3, r3=5 -> r0=f, flags={0,0,0,0}.
REQ-038 Backpressure: hold out_ready=0 after an ADD; issue OR with in_valid=1 -> OR not accepted, r0 stable; raise out_ready -> ADD consumed, OR accepted in the same cycle, OR result valid next cycle.
REQ-039 Assert rst 10 cycles into a MUL -> next cycle out_valid=0, r0=0; after release in_ready=1, and a new MOV r2=b1ee_c082 returns r0=b1ee_c082 with no stale MUL result ever appearing.
